// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the requesters, the consumer and alu_rr_scheduler.
// Requester i's operands and opcode are packed at [8i+7:8i] and [3i+2:3i].
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [3*NUM_REQ-1:0] req_sel;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ requesters.
// Illegal opcodes and divide-by-zero are answered directly and never reach the ALU.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_rr_scheduler_if.slave    bus,
    output logic                 busy,
    output logic [7:0]           alu_number1,
    output logic [7:0]           alu_number2,
    output logic [2:0]           alu_sel,
    input  logic [15:0]          alu_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      n1_q, n1_d;
    logic [7:0]      n2_q, n2_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [7:0] a_arr   [NUM_REQ];
    logic [7:0] b_arr   [NUM_REQ];
    logic [2:0] sel_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]   = bus.req_a[8*gi +: 8];
            assign b_arr[gi]   = bus.req_b[8*gi +: 8];
            assign sel_arr[gi] = bus.req_sel[3*gi +: 3];
        end
    endgenerate

    // Round-robin search starting just after the last granted requester.
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [ID_W:0]      idx_sum;
    logic [ID_W-1:0]    idx;

    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        idx_sum   = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
            end
            idx = idx_sum[ID_W-1:0];
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        if (state_q != IDLE || !rst_n) begin
            grant_any = 1'b0;
        end
        grant = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    end

    logic [2:0] in_sel;
    logic [7:0] in_b;
    logic       in_div0;
    logic       in_legal;

    always_comb begin
        in_sel   = sel_arr[grant_id];
        in_b     = b_arr[grant_id];
        in_div0  = (in_sel == 3'b100) && (in_b == 8'd0);
        in_legal = (in_sel != 3'b000) && (in_sel <= 3'b100);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        sel_d      = sel_q;
        n1_d       = n1_q;
        n2_d       = n2_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    ptr_d    = grant_id;
                    rsp_id_d = grant_id;
                    sel_d    = in_sel;
                    if (in_legal && !in_div0) begin
                        n1_d      = a_arr[grant_id];
                        n2_d      = in_b;
                        rsp_err_d = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        // Errors skip ISSUE but still pass through WAIT, which
                        // leaves the pre-loaded error response untouched.
                        rsp_err_d  = 1'b1;
                        rsp_data_d = in_div0 ? 16'hFFFF : 16'h0000;
                        state_d    = WAIT;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!rsp_err_q) begin
                    rsp_data_d = alu_out;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            rsp_id_q   <= '0;
            sel_q      <= '0;
            n1_q       <= '0;
            n2_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            sel_q      <= sel_d;
            n1_q       <= n1_d;
            n2_q       <= n2_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != IDLE);
    assign alu_sel       = (state_q == ISSUE) ? sel_q : 3'b000;
    assign alu_number1   = n1_q;
    assign alu_number2   = n2_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural registered ALU attached.
// Expected values are hand-computed constants.
module tb_alu_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [7:0]  alu_number1;
    logic [7:0]  alu_number2;
    logic [2:0]  alu_sel;
    logic [15:0] alu_out;

    int n_checks = 0;
    int n_errors = 0;

    alu_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .busy        (busy),
        .alu_number1 (alu_number1),
        .alu_number2 (alu_number2),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: result registered one cycle after the opcode is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out <= 16'h0000;
        end else begin
            case (alu_sel)
                3'b001: alu_out <= {8'h00, alu_number1} + {8'h00, alu_number2};
                3'b010: alu_out <= {8'h00, alu_number1} - {8'h00, alu_number2};
                3'b011: alu_out <= {8'h00, alu_number1} * {8'h00, alu_number2};
                3'b100: alu_out <= (alu_number2 != 8'd0) ? {8'h00, alu_number1 / alu_number2} : 16'hDEAD;
                default: alu_out <= alu_out;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        bus.req_valid[id]     = 1'b1;
        bus.req_a[8*id +: 8]  = a;
        bus.req_b[8*id +: 8]  = b;
        bus.req_sel[3*id +: 3] = sel;
    endtask

    // Wait for rsp_valid, returning cycles counted from the handshake edge.
    task automatic wait_rsp(output int lat, output bit saw_div);
        lat     = 1;
        saw_div = 1'b0;
        while (!bus.rsp_valid && lat < 8) begin
            if (alu_sel == 3'b100) saw_div = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                         input logic [15:0] exp_data, input bit exp_err);
        int lat;
        bit saw_div;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        drive_req(id, a, b, sel);
        #1;
        check("grant_onehot", bus.req_ready, 32'(1) << id);
        tick();
        bus.req_valid[id] = 1'b0;
        check("ready_after_grant", bus.req_ready, 0);
        if (!exp_err) begin
            check("issue_sel", alu_sel, sel);
            check("issue_a", alu_number1, a);
            check("issue_b", alu_number2, b);
        end
        wait_rsp(lat, saw_div);
        check("latency", lat, exp_err ? 2 : 3);
        check("rsp_id", bus.rsp_id, id);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_err", bus.rsp_err, exp_err);
        if (exp_err) check("no_div_issue", saw_div, 0);
        tick();
        check("idle_after_rsp", busy, 0);
    endtask

    initial begin
        int lat;
        bit saw_div;
        int rr_order [6] = '{0, 1, 2, 3, 0, 1};

        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_alu_n1", alu_number1, 0);
        check("rst_req_ready", bus.req_ready, 0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();

        do_op(1, 8'd200, 8'd100, 3'b001, 16'd300, 1'b0);
        do_op(0, 8'd3, 8'd5, 3'b010, 16'hFFFE, 1'b0);
        do_op(2, 8'd255, 8'd255, 3'b011, 16'hFE01, 1'b0);
        do_op(3, 8'd7, 8'd2, 3'b100, 16'd3, 1'b0);
        do_op(1, 8'd9, 8'd0, 3'b100, 16'hFFFF, 1'b1);
        do_op(2, 8'd5, 8'd6, 3'b111, 16'h0000, 1'b1);
        do_op(0, 8'd1, 8'd1, 3'b000, 16'h0000, 1'b1);
        check("operands_held", alu_number1, 8'd7);

        // Round robin from a fresh pointer with all requesters valid.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, 8'(i + 1), 8'd10, 3'b001);
        bus.rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
            int n;
            n = 0;
            while (bus.req_ready == '0 && n < 8) begin
                tick();
                n++;
            end
            check("rr_grant", bus.req_ready, 32'(1) << rr_order[g]);
            tick();
            wait_rsp(lat, saw_div);
            check("rr_rsp_id", bus.rsp_id, rr_order[g]);
            check("rr_rsp_data", bus.rsp_data, rr_order[g] + 11);
            tick();
        end
        bus.req_valid = '0;

        // Backpressure: pointer restarts, requester 2 wins, requester 0 waits.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b0;
        drive_req(2, 8'd12, 8'd13, 3'b011);
        #1;
        check("bp_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        drive_req(0, 8'd1, 8'd1, 3'b001);
        wait_rsp(lat, saw_div);
        check("bp_latency", lat, 3);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_id", bus.rsp_id, 2);
            check("bp_data", bus.rsp_data, 16'd156);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_next_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        wait_rsp(lat, saw_div);
        check("bp_next_id", bus.rsp_id, 0);
        check("bp_next_data", bus.rsp_data, 16'd2);
        tick();

        // Reset during WAIT discards the op.
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, 8'(i + 1), 8'd20, 3'b001);
        #1;
        check("mid_grant", bus.req_ready, 4'b0010);
        tick();
        tick();
        check("mid_wait_busy", busy, 1);
        check("mid_wait_valid", bus.rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", bus.req_ready, 0);
        tick();
        check("mid_rsp_valid", bus.rsp_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_rsp_data", bus.rsp_data, 0);
        rst_n = 1'b1;
        #1;
        check("mid_first_grant", bus.req_ready, 4'b0001);
        tick();
        check("mid_no_stale", bus.rsp_valid, 0);
        bus.req_valid = '0;
        wait_rsp(lat, saw_div);
        check("mid_latency", lat, 3);
        check("mid_rsp_id", bus.rsp_id, 0);
        check("mid_rsp_data", bus.rsp_data, 16'd21);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
